pri_request_capture: RTL



---
 rtl/pri_request_capture.sv | 117 +++++++++++
 1 files changed

// File: rtl/pri_request_capture.sv
// Request capture ahead of the priority encoder: latches request pulses into a pending set,
// picks the lowest-numbered eligible bit and offers its index on a valid/ready handshake.
// Optional build macro PRI_REQ_EDGE_EN: capture rising edges of req_in instead of levels.
// IDX_W must be at least clog2(WIDTH); indices are zero-extended into IDX_W bits.
module pri_request_capture #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] req_mask,
  input  logic             out_ready,
  input  logic             clear_lost,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] pending,
  output logic             lost,
  output logic [1:0]       fsm_state
);

  // Handshake: out_valid rises with out_index already stable; both hold until the
  // cycle where out_valid & out_ready are sampled high, which is the single transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] new_req;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] elig;
  logic             elig_any;
  logic [IDX_W-1:0] low_idx;

`ifdef PRI_REQ_EDGE_EN
  logic [WIDTH-1:0] req_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_in;
    end
  end

  assign new_req = req_in & ~req_q;
`else
  assign new_req = req_in;
`endif

  assign clr       = (out_valid && out_ready) ? (WIDTH'(1) << out_index) : '0;
  assign elig      = pending & req_mask;
  assign elig_any  = |elig;
  assign fsm_state = state;

  // Scan downward so the lowest set bit is the last to write: bit 0 wins.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (elig[i]) low_idx = IDX_W'(i);
    end
  end

  // A new request on the bit being cleared keeps it pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
      lost    <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | new_req;
      if (|(new_req & pending & ~clr)) begin
        lost <= 1'b1;
      end else if (clear_lost) begin
        lost <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && elig_any) state <= SELECT;
        end
        SELECT: begin
          if (elig_any) begin
            out_index <= low_idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end else begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        OFFER: begin
          // Mask and enable are ignored here so an offer is never withdrawn.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
